// File: rtl/tmr_mon_pkg.sv
// Shared types and helpers for the TMR upset monitor.
package tmr_mon_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        UPSET = 2'd1,
        FAULT = 2'd2
    } monState_t;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] satInc(input logic [31:0] val, input int width);
        logic [31:0] maxVal;
        maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= maxVal) ? maxVal : (val + 32'd1);
    endfunction

endpackage

// File: rtl/majorityVoter.sv
// Single-bit 2-of-3 majority voter.
module majorityVoter (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = (a & b) | (b & c) | (a & c);
endmodule

// File: rtl/tmr_upset_monitor.sv
// De-triplicates a TMR register: registered vote, upset/fault classification
// and per-lane saturating mismatch counters.
module tmr_upset_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             upset,
    output logic             multiUpset,
    output logic             fault,
    output logic [1:0]       faultLane,
    output logic [CNT_W-1:0] errA,
    output logic [CNT_W-1:0] errB,
    output logic [CNT_W-1:0] errC
);

    localparam logic [7:0] PERSIST_L = 8'(PERSIST);

    logic [WIDTH-1:0] vote;
    logic             mmA, mmB, mmC;
    logic [1:0]       mmCnt;
    logic             anyMm, singleMm, multiMm;
    logic [1:0]       mmLane;

    monState_t  state, stateNext;
    logic [7:0] runLen, runLenNext;
    logic [1:0] runLane, runLaneNext;
    logic       upsetNext;
    logic [1:0] faultLaneNext;

    for (genvar i = 0; i < WIDTH; i++) begin : gVote
        majorityVoter uVote (
            .a (inA[i]),
            .b (inB[i]),
            .c (inC[i]),
            .y (vote[i])
        );
    end

    assign mmA      = |(inA ^ vote);
    assign mmB      = |(inB ^ vote);
    assign mmC      = |(inC ^ vote);
    assign mmCnt    = {1'b0, mmA} + {1'b0, mmB} + {1'b0, mmC};
    assign anyMm    = (mmCnt != 2'd0);
    assign singleMm = (mmCnt == 2'd1);
    assign multiMm  = (mmCnt >= 2'd2);
    assign mmLane   = mmA ? LANE_A : (mmB ? LANE_B : LANE_C);
    assign fault    = (state == FAULT);

    // Run tracker: length of the current streak of single-lane mismatches on one lane.
    always_comb begin
        runLenNext  = 8'd0;
        runLaneNext = runLane;
        if (singleMm) begin
            runLaneNext = mmLane;
            runLenNext  = (mmLane == runLane) ? 8'(satInc(32'(runLen), 8)) : 8'd1;
        end
    end

    // Classification FSM; clear overrides whatever this sample shows.
    always_comb begin
        stateNext     = state;
        upsetNext     = 1'b0;
        faultLaneNext = faultLane;
        if (clear) begin
            stateNext     = CLEAN;
            faultLaneNext = 2'd0;
        end else begin
            case (state)
                CLEAN: begin
                    if (anyMm) begin
                        stateNext = UPSET;
                        upsetNext = 1'b1;
                    end
                end
                UPSET: begin
                    if (!anyMm) begin
                        stateNext = CLEAN;
                    end else if (singleMm && (runLenNext >= PERSIST_L)) begin
                        stateNext     = FAULT;
                        faultLaneNext = mmLane;
                    end
                end
                FAULT:   stateNext = FAULT;
                default: stateNext = CLEAN;
            endcase
        end
    end

    // State, pulses, vote register and run tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAN;
            out        <= '0;
            upset      <= 1'b0;
            multiUpset <= 1'b0;
            faultLane  <= 2'd0;
            runLen     <= 8'd0;
            runLane    <= LANE_A;
        end else begin
            state      <= stateNext;
            out        <= vote;
            upset      <= upsetNext;
            multiUpset <= multiMm & ~clear;
            faultLane  <= faultLaneNext;
            if (clear) begin
                runLen  <= 8'd0;
                runLane <= LANE_A;
            end else begin
                runLen  <= runLenNext;
                runLane <= runLaneNext;
            end
        end
    end

    // Per-lane saturating mismatch counters; clear wins over a same-cycle mismatch.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            errA <= '0;
            errB <= '0;
            errC <= '0;
        end else begin
            if (mmA) errA <= CNT_W'(satInc(32'(errA), CNT_W));
            if (mmB) errB <= CNT_W'(satInc(32'(errB), CNT_W));
            if (mmC) errC <= CNT_W'(satInc(32'(errC), CNT_W));
        end
    end

endmodule

// File: tb/tb_tmr_upset_monitor.sv
// Directed bench for tmr_upset_monitor (WIDTH=8, CNT_W=4, PERSIST=4).
module tb_tmr_upset_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inA, inB, inC;
    logic       clear;
    logic [7:0] out;
    logic       upset, multiUpset, fault;
    logic [1:0] faultLane;
    logic [3:0] errA, errB, errC;

    int nAssert = 0;
    int nFail   = 0;

    tmr_upset_monitor #(.WIDTH(8), .CNT_W(4), .PERSIST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .inA        (inA),
        .inB        (inB),
        .inC        (inC),
        .clear      (clear),
        .out        (out),
        .upset      (upset),
        .multiUpset (multiUpset),
        .fault      (fault),
        .faultLane  (faultLane),
        .errA       (errA),
        .errB       (errB),
        .errC       (errC)
    );

    always #5 clk = ~clk;

    // Apply one sample, clock it in, then settle 1 time unit past the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic clr);
        inA   = a;
        inB   = b;
        inC   = c;
        clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        step(8'hA5, 8'h00, 8'hFF, 1'b1);
        step(8'hA5, 8'h00, 8'hFF, 1'b0);
        chk("rst out", 32'(out), 32'h0);
        chk("rst upset", 32'(upset), 32'h0);
        chk("rst multi", 32'(multiUpset), 32'h0);
        chk("rst fault", 32'(fault), 32'h0);
        chk("rst faultLane", 32'(faultLane), 32'h0);
        chk("rst errA", 32'(errA), 32'h0);
        chk("rst errB", 32'(errB), 32'h0);
        chk("rst errC", 32'(errC), 32'h0);
        rst = 1'b0;

        // 1: agreeing lanes
        for (int i = 0; i < 10; i++) begin
            step(8'h5A, 8'h5A, 8'h5A, 1'b0);
            chk("t1 out", 32'(out), 32'h5A);
            chk("t1 upset", 32'(upset), 32'h0);
        end
        chk("t1 errA", 32'(errA), 32'h0);
        chk("t1 errB", 32'(errB), 32'h0);
        chk("t1 errC", 32'(errC), 32'h0);
        chk("t1 fault", 32'(fault), 32'h0);

        // 2: single transient on B
        step(8'h5A, 8'h5B, 8'h5A, 1'b0);
        chk("t2 out", 32'(out), 32'h5A);
        chk("t2 upset", 32'(upset), 32'h1);
        chk("t2 multi", 32'(multiUpset), 32'h0);
        chk("t2 errB", 32'(errB), 32'h1);
        chk("t2 errA", 32'(errA), 32'h0);
        step(8'h5A, 8'h5A, 8'h5A, 1'b0);
        chk("t2 upset drop", 32'(upset), 32'h0);
        step(8'h5A, 8'h5B, 8'h5A, 1'b0);
        chk("t2 reupset", 32'(upset), 32'h1);
        chk("t2 errB 2", 32'(errB), 32'h2);
        step(8'h5A, 8'h5A, 8'h5A, 1'b1);
        chk("t2 clear errB", 32'(errB), 32'h0);

        // 3: persistent fault on C
        for (int i = 0; i < 4; i++) begin
            step(8'hFF, 8'hFF, 8'h00, 1'b0);
            chk("t3 out", 32'(out), 32'hFF);
            chk("t3 upset", 32'(upset), (i == 0) ? 32'h1 : 32'h0);
            chk("t3 fault", 32'(fault), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("t3 faultLane", 32'(faultLane), 32'h2);
        chk("t3 errC", 32'(errC), 32'h4);
        step(8'hFF, 8'hFF, 8'hFF, 1'b0);
        step(8'hFF, 8'hFF, 8'hFF, 1'b0);
        chk("t3 fault sticky", 32'(fault), 32'h1);
        chk("t3 lane sticky", 32'(faultLane), 32'h2);
        step(8'hFF, 8'hFF, 8'hFF, 1'b1);
        chk("t3 clear fault", 32'(fault), 32'h0);
        chk("t3 clear errC", 32'(errC), 32'h0);
        chk("t3 clear lane", 32'(faultLane), 32'h0);

        // 4: multi upset, A bit0 and B bit7
        for (int i = 0; i < 4; i++) begin
            step(8'h5B, 8'hDA, 8'h5A, 1'b0);
            chk("t4 multi", 32'(multiUpset), 32'h1);
            chk("t4 out", 32'(out), 32'h5A);
            chk("t4 upset", 32'(upset), (i == 0) ? 32'h1 : 32'h0);
            chk("t4 fault", 32'(fault), 32'h0);
        end
        chk("t4 errA", 32'(errA), 32'h4);
        chk("t4 errB", 32'(errB), 32'h4);
        chk("t4 errC", 32'(errC), 32'h0);
        step(8'h5A, 8'h5A, 8'h5A, 1'b0);
        chk("t4 multi drop", 32'(multiUpset), 32'h0);
        step(8'h5A, 8'h5A, 8'h5A, 1'b1);
        chk("t4 clear errA", 32'(errA), 32'h0);

        // 5: A/B alternating every 3 samples, never faults, counters saturate
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) begin
                step(8'h5B, 8'h5A, 8'h5A, 1'b0);
                chk("t5 fault A", 32'(fault), 32'h0);
            end
            for (int i = 0; i < 3; i++) begin
                step(8'h5A, 8'h5B, 8'h5A, 1'b0);
                chk("t5 fault B", 32'(fault), 32'h0);
            end
        end
        chk("t5 errA sat", 32'(errA), 32'hF);
        chk("t5 errB sat", 32'(errB), 32'hF);
        chk("t5 errC", 32'(errC), 32'h0);
        step(8'h5B, 8'h5A, 8'h5A, 1'b1);
        chk("t5 sat clear errA", 32'(errA), 32'h0);
        chk("t5 sat clear errB", 32'(errB), 32'h0);
        chk("t5 clear upset", 32'(upset), 32'h0);

        // 6: reset beats clear while in FAULT
        for (int i = 0; i < 4; i++) step(8'hFF, 8'hFF, 8'h00, 1'b0);
        chk("t6 fault", 32'(fault), 32'h1);
        rst = 1'b1;
        step(8'hFF, 8'h0F, 8'h00, 1'b1);
        chk("t6 rst out", 32'(out), 32'h0);
        chk("t6 rst fault", 32'(fault), 32'h0);
        chk("t6 rst lane", 32'(faultLane), 32'h0);
        chk("t6 rst errC", 32'(errC), 32'h0);
        chk("t6 rst upset", 32'(upset), 32'h0);
        chk("t6 rst multi", 32'(multiUpset), 32'h0);
        rst = 1'b0;

        // 6: mismatch concurrent with clear is dropped
        step(8'h5B, 8'h5A, 8'h5A, 1'b0);
        chk("t6 errA", 32'(errA), 32'h1);
        chk("t6 upset", 32'(upset), 32'h1);
        step(8'h5A, 8'h5A, 8'h5A, 1'b0);
        step(8'h5B, 8'h5A, 8'h5A, 1'b1);
        chk("t6 clr errA", 32'(errA), 32'h0);
        chk("t6 clr upset", 32'(upset), 32'h0);
        step(8'h5A, 8'h5A, 8'h5A, 1'b0);
        chk("t6 idle upset", 32'(upset), 32'h0);
        step(8'h5B, 8'h5A, 8'h5A, 1'b0);
        chk("t6 resume upset", 32'(upset), 32'h1);
        chk("t6 resume errA", 32'(errA), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
